// File: rtl/ex_div_seq_if.sv
// Handshake bundle between the EX stage and the sequential divider.
// The master side is the pipeline; the slave side is the divider.
interface ex_div_seq_if;
    logic        div_req;
    logic [1:0]  div_op;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_flush;
    logic        div_busy;
    logic        div_valid;
    logic [31:0] div_result;

    modport master (
        output div_req, div_op, div_dividend, div_divisor, div_flush,
        input  div_busy, div_valid, div_result
    );

    modport slave (
        input  div_req, div_op, div_dividend, div_divisor, div_flush,
        output div_busy, div_valid, div_result
    );
endinterface

// File: rtl/ex_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish one cycle after accept.
module ex_div_seq (
    input  logic          clk,
    input  logic          rst,
    ex_div_seq_if.slave   bus_io
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] divisor_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [4:0]  cnt_q;
    logic        neg_dvd_q;
    logic        neg_dvs_q;
    logic [31:0] result_q;

    logic        is_signed;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic        overflow;
    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic        q_bit;
    logic [31:0] rem_nxt;
    logic [31:0] quot_nxt;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_res;

    always_comb begin
        is_signed = ~bus_io.div_op[0];
        dvd_neg   = is_signed & bus_io.div_dividend[31];
        dvs_neg   = is_signed & bus_io.div_divisor[31];
        dvd_abs   = dvd_neg ? (32'd0 - bus_io.div_dividend) : bus_io.div_dividend;
        dvs_abs   = dvs_neg ? (32'd0 - bus_io.div_divisor) : bus_io.div_divisor;
        overflow  = is_signed && (bus_io.div_dividend == 32'h8000_0000)
                    && (bus_io.div_divisor == 32'hFFFF_FFFF);

        // Dividend bits stream out of quot_q's MSB while quotient bits enter at its LSB.
        rem_shift = {rem_q, quot_q[31]};
        rem_sub   = rem_shift - {1'b0, divisor_q};
        q_bit     = ~rem_sub[32];
        rem_nxt   = q_bit ? rem_sub[31:0] : rem_shift[31:0];
        quot_nxt  = {quot_q[30:0], q_bit};

        quot_fix  = (neg_dvd_q ^ neg_dvs_q) ? (32'd0 - quot_nxt) : quot_nxt;
        rem_fix   = neg_dvd_q ? (32'd0 - rem_nxt) : rem_nxt;
        final_res = op_q[1] ? rem_fix : quot_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= 2'b00;
            divisor_q <= 32'd0;
            quot_q    <= 32'd0;
            rem_q     <= 32'd0;
            cnt_q     <= 5'd0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result_q  <= 32'd0;
        end else if (bus_io.div_flush) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.div_req) begin
                        op_q      <= bus_io.div_op;
                        neg_dvd_q <= dvd_neg;
                        neg_dvs_q <= dvs_neg;
                        divisor_q <= dvs_abs;
                        quot_q    <= dvd_abs;
                        rem_q     <= 32'd0;
                        cnt_q     <= 5'd0;
                        if (bus_io.div_divisor == 32'd0) begin
                            result_q <= bus_io.div_op[1] ? bus_io.div_dividend : 32'hFFFF_FFFF;
                            state_q  <= StDone;
                        end else if (overflow) begin
                            result_q <= bus_io.div_op[1] ? 32'd0 : 32'h8000_0000;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_q  <= rem_nxt;
                    quot_q <= quot_nxt;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= final_res;
                        state_q  <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.div_busy   = ((state_q == StIdle) & bus_io.div_req & ~bus_io.div_flush)
                               | (state_q == StCalc);
    assign bus_io.div_valid  = (state_q == StDone) & ~bus_io.div_flush;
    assign bus_io.div_result = bus_io.div_valid ? result_q : 32'd0;

endmodule

// File: doc/ex_div_seq.md
EX_DIV_SEQ -- requirements
Module: ex_div_seq

Interface
REQ-001 Parameters SHALL be none; all data ports SHALL be 32 bits, equal to `RegBus.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 div_req  input  1  EX holds a divide/remainder instruction; held high while stalled.
REQ-005 div_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 div_dividend  input  32  forwarded rs1 value.
REQ-007 div_divisor  input  32  forwarded rs2 value.
REQ-008 div_flush  input  1  pipeline flush (jump or trap); cancels any operation.
REQ-009 div_busy  output  1  stall request to pipeline control.
REQ-010 div_valid  output  1  one-cycle result strobe.
REQ-011 div_result  output  32  quotient or remainder; SHALL be valid only while div_valid=1.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE.
REQ-013 In IDLE, div_req=1 with div_flush=0 SHALL accept the operation (cycle T) and latch div_op, |dividend|, |divisor| and both sign bits.
- Absolute values SHALL apply to DIV/REM only.
- DIVU/REMU SHALL take operands unsigned.
REQ-014 Divisor==0 at accept SHALL take the shortcut IDLE->DONE.
- Quotient SHALL be 0xFFFFFFFF.
- Remainder SHALL be the raw dividend.
REQ-015 Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF) SHALL take the shortcut IDLE->DONE.
- Quotient SHALL be 0x80000000.
- Remainder SHALL be 0.
REQ-016 Otherwise IDLE->CALC; CALC SHALL run restoring division, one quotient bit per cycle, MSB first, using a 33-bit partial remainder, for exactly 32 cycles (T+1..T+32), then go to DONE.
REQ-017 In DONE (T+33 normal, T+1 shortcut) the block SHALL:
- drive div_valid=1 and div_result;
- select the quotient for DIV/DIVU and the remainder for REM/REMU;
- negate the quotient when operand signs differ (DIV);
- negate the remainder when the dividend is negative (REM).
REQ-018 DONE SHALL always return to IDLE the next cycle; div_req SHALL be ignored in DONE.
REQ-019 div_busy SHALL be combinational: (IDLE & div_req & ~div_flush) | CALC.
- div_busy SHALL be 0 in DONE so the pipeline advances in that cycle.
REQ-020 div_valid SHALL be 1 only in DONE and never for more than one consecutive cycle per accepted operation.
REQ-021 div_flush=1 in any state SHALL force IDLE next cycle.
- div_flush=1 SHALL suppress div_valid in that cycle (div_valid = DONE & ~div_flush).
- Latched operands SHALL be discarded.
REQ-022 A div_req present in the cycle after DONE SHALL be treated as a new instruction; back-to-back operations SHALL be accepted without an idle gap.
REQ-023 Operand inputs SHALL NOT affect an operation after the accept cycle.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, regardless of state (including mid-CALC).
REQ-025 rst=1 at an edge SHALL clear the iteration counter, partial remainder and quotient registers.
REQ-026 After reset, div_busy=0, div_valid=0 and div_result=0x00000000 SHALL hold until the next accept.
REQ-027 div_result SHALL read 0 whenever div_valid=0.

Verification
REQ-028 DIVU 100/7 accepted at T -> div_busy=1 T..T+32, div_valid=1 at T+33 with result 0x0000000E; REMU same operands -> 0x00000002.
REQ-029 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD at T+33; REM same operands -> 0xFFFFFFFF.
REQ-030 DIVU 5/0 -> div_valid at T+1, result 0xFFFFFFFF; REM 5/0 -> 0x00000005; div_busy=1 only in cycle T.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM same operands -> 0x00000000.
REQ-032 Flush and reset cases:
- DIVU accepted at T, div_flush=1 at T+10 -> IDLE at T+11, no div_valid; new DIVU 9/3 at T+11 -> 0x00000003 at T+44.
- rst at T+5 mid-CALC -> all outputs 0 at T+6.
REQ-033 Two consecutive DIVU ops with div_req held high -> valid strobes at T+33 and T+67; operands changed during CALC do not alter the first result.
